// File: rtl/alu_zero_selftest.sv
// alu_zero_selftest: sweeps dut_a 0..2^WIDTH-1, holds each SETTLE cycles, checks dut_c==(dut_a==0), reports busy/done/pass/err_count/first_err
module alu_zero_selftest #(
  parameter int WIDTH = 6,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_err
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [WIDTH-1:0] a_n, fe_n, expected;
  logic [WIDTH:0] ec_n;
  logic bad;
  always_comb begin
    expected = WIDTH'(dut_a == '0);
    bad = !(dut_c === expected);
    state_n = state;
    cnt_n = cnt;
    a_n = dut_a;
    ec_n = err_count;
    fe_n = first_err;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = DRIVE;
        cnt_n = '0;
        a_n = '0;
        ec_n = '0;
        fe_n = '0;
      end
      DRIVE: begin
        cnt_n = cnt + 4'd1;
        state_n = (cnt == LAST) ? CHECK : DRIVE;
      end
      default: begin
        ec_n = bad ? err_count + 1'b1 : err_count;
        fe_n = (bad && err_count == '0) ? dut_a : first_err;
        state_n = (dut_a == MAX) ? DONE : DRIVE;
        a_n = (dut_a == MAX) ? dut_a : dut_a + 1'b1;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dut_a <= '0;
      err_count <= '0;
      first_err <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dut_a <= a_n;
      err_count <= ec_n;
      first_err <= fe_n;
      busy <= (state_n == DRIVE) || (state_n == CHECK);
      done <= state_n == DONE;
      pass <= (state_n == DONE) && (ec_n == '0);
    end
  end
endmodule

// File: tb/tb_alu_zero_selftest.sv
// tb_alu_zero_selftest: directed table-driven bench for alu_zero_selftest with behavioural zero-detect models
module tb_alu_zero_selftest;
  logic clk = 0, reset = 1, start = 0, start1 = 0;
  always #5 clk = ~clk;
  logic [5:0] dut_a, dut_c, first_err, dut_a1, dut_c1, first_err1;
  logic [6:0] err_count, err_count1;
  logic busy, done, pass, busy1, done1, pass1;
  int mode = 0, mode1 = 0, checks = 0, fails = 0;
  typedef struct {int mode; int ec; int fe; int pass;} vec_t;
  vec_t vecs[4];
  function automatic logic [5:0] model(int m, logic [5:0] a);
    case (m)
      0: return {5'b0, a == 0};
      1: return 6'd0;
      2: return {5'b0, a != 0};
      default: return {5'b0, a == 0 || a == 37 || a == 50};
    endcase
  endfunction
  assign dut_c = model(mode, dut_a);
  assign dut_c1 = model(mode1, dut_a1);
  alu_zero_selftest #(.WIDTH(6), .SETTLE(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_a(dut_a), .dut_c(dut_c),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err(first_err)
  );
  alu_zero_selftest #(.WIDTH(6), .SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .dut_a(dut_a1), .dut_c(dut_c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .first_err(first_err1)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_sweep(output int lat, output int step_err);
    lat = -1;
    step_err = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int k = 0; k <= 400; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (dut_a !== 6'(k / 3) || !busy) step_err++;
    end
  endtask
  initial begin
    int lat, se;
    vecs[0] = '{0, 0, 0, 1};
    vecs[1] = '{1, 1, 0, 0};
    vecs[2] = '{2, 64, 0, 0};
    vecs[3] = '{3, 2, 37, 0};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ec", err_count, 0);
    chk("rst_fe", first_err, 0);
    chk("rst_a", dut_a, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_a", dut_a, 0);
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_sweep(lat, se);
      chk($sformatf("v%0d_latency", i), lat, 192);
      chk($sformatf("v%0d_steps", i), se, 0);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].pass);
      chk($sformatf("v%0d_ec", i), err_count, vecs[i].ec);
      chk($sformatf("v%0d_fe", i), first_err, vecs[i].fe);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_a_hold", i), dut_a, 63);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_done_held", i), done, 1);
      chk($sformatf("v%0d_ec_held", i), err_count, vecs[i].ec);
    end
    mode = 1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (50) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1;
    @(negedge clk) reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_ec", err_count, 0);
    chk("abort_fe", first_err, 0);
    chk("abort_a", dut_a, 0);
    reset = 1;
    start = 1;
    @(negedge clk);
    chk("prio_busy", busy, 0);
    reset = 0;
    start = 0;
    @(negedge clk);
    chk("prio_idle", busy, 0);
    mode = 0;
    run_sweep(lat, se);
    chk("after_rst_latency", lat, 192);
    chk("after_rst_steps", se, 0);
    chk("after_rst_pass", pass, 1);
    mode1 = 1;
    lat = -1;
    @(negedge clk) start1 = 1;
    @(negedge clk) start1 = 0;
    for (int k = 0; k <= 400; k++) begin
      if (k > 0) @(negedge clk);
      if (done1) begin
        lat = k;
        break;
      end
      start1 = (k == 40);
    end
    start1 = 0;
    chk("s1_latency_ignore", lat, 128);
    chk("s1_ec", err_count1, 1);
    chk("s1_pass", pass1, 0);
    mode1 = 0;
    @(negedge clk) start1 = 1;
    @(negedge clk) start1 = 0;
    chk("s1_restart_busy", busy1, 1);
    chk("s1_restart_done", done1, 0);
    chk("s1_restart_ec", err_count1, 0);
    chk("s1_restart_a", dut_a1, 0);
    lat = -1;
    for (int k = 0; k <= 400; k++) begin
      if (k > 0) @(negedge clk);
      if (done1) begin
        lat = k;
        break;
      end
    end
    chk("s1_latency", lat, 128);
    chk("s1_pass2", pass1, 1);
    chk("s1_ec2", err_count1, 0);
    chk("s1_fe2", first_err1, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/alu_zero_selftest.md
ALU_ZERO_SELFTEST -- requirements
Module: alu_zero_selftest

Parameters
REQ-001 SHALL have parameter WIDTH, default 6, operand width driven to the zero-detect unit under test.
REQ-002 SHALL have parameter SETTLE, default 2, number of cycles (range 1-15) each operand is held before the response is sampled.

Interface
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to run one full sweep; sampled only in IDLE or DONE.
REQ-006 SHALL have port dut_a  output  WIDTH  operand driven to the zero-detect unit.
REQ-007 SHALL have port dut_c  input  WIDTH  zero-detect response from the unit.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  level, high from sweep completion until the next accepted start or reset.
REQ-010 SHALL have port pass  output  1  valid while done is high; 1 iff err_count == 0.
REQ-011 SHALL have port err_count  output  WIDTH+1  number of mismatching operands in the last sweep.
REQ-012 SHALL have port first_err  output  WIDTH  operand value of the first mismatch; 0 if none.

Function
REQ-013 SHALL implement a state machine with states IDLE, DRIVE, CHECK, DONE.
REQ-014 IDLE: busy=0, done=0, dut_a=0; start=1 -> DRIVE, with err_count, first_err and the settle counter cleared.
REQ-015 DRIVE: busy=1; dut_a held stable; settle counter increments each cycle; after SETTLE cycles in DRIVE -> CHECK.
REQ-016 CHECK (one cycle): sample dut_c; expected = 1 (zero-extended to WIDTH) if dut_a == 0, otherwise 0; full-width compare, so any X/unexpected bit counts as a mismatch.
REQ-017 On mismatch in CHECK: err_count increments by 1; if this is the first mismatch of the sweep, first_err <= dut_a.
REQ-018 CHECK with dut_a < 2^WIDTH-1: dut_a <= dut_a+1, settle counter cleared -> DRIVE.
REQ-019 CHECK with dut_a == 2^WIDTH-1: -> DONE; dut_a SHALL NOT wrap to 0 during the sweep, but holds at 2^WIDTH-1 in DONE.
REQ-020 Sweep latency: done SHALL rise exactly 2^WIDTH*(SETTLE+1) cycles after the edge that samples start (192 for the defaults).
REQ-021 err_count SHALL never overflow, since the maximum value is 2^WIDTH and the port is WIDTH+1 bits wide.
REQ-022 DONE: busy=0, done=1; pass, err_count and first_err held; start=1 -> DRIVE with dut_a=0 and results cleared, identical to IDLE acceptance.
REQ-023 start while in DRIVE or CHECK SHALL be ignored without restarting or perturbing the sweep.
REQ-024 All outputs SHALL be registered; no combinational path from dut_c or start to any output.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, dut_a=0, busy=0, done=0, pass=0, err_count=0, first_err=0, settle counter=0, from any state.
REQ-026 Reset SHALL take priority over start in the same cycle; a sweep aborted by reset leaves no residual results.

Verification
REQ-027 Golden model (dut_c = (dut_a==0)?1:0), start pulse -> done rises after exactly 192 cycles, pass=1, err_count=0, first_err=0, and dut_a steps 0..63 with each value held 3 cycles.
REQ-028 Stuck-at-zero model (dut_c=0 always) -> err_count=1, first_err=0, pass=0.
REQ-029 Inverted model (dut_c = (dut_a==0)?0:1) -> err_count=64, first_err=0, pass=0; err_count does not wrap.
REQ-030 Model failing only at dut_a=37 and dut_a=50 -> err_count=2, first_err=37.
REQ-031 reset asserted for 1 cycle at cycle 50 of a sweep -> all outputs at reset values next cycle; a new start then completes normally in 192 cycles.
REQ-032 start re-pulsed mid-sweep and again in DONE with SETTLE=1 -> the mid-sweep pulse is ignored; the DONE pulse restarts with cleared results; done rises after 128 cycles.
